rf_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of the 16-entry register file among NUM_REQ requesters.

---
 rtl/rf_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter that shares the single write port of
// the 16-entry register file among NUM_REQ writers (execute, load, CSR, ...).
// The winning request is registered onto wr_ena/wr_addr/wr_data. A
// decoder_4_to_16 instance turns that registered address into one-hot word lines.
//
// Optional build macro RF_ARB_STATS_EN adds two saturating 16-bit
// statistics outputs: stat_grants and stat_stalls.

// 4-to-16 one-hot decoder with enable; all outputs low while ena is low.
module decoder_4_to_16 (
  input  logic        ena,
  input  logic [3:0]  in,
  output logic [15:0] out
);

  // One word line per address, gated by the enable
  always_comb begin
    out = '0;
    for (int i = 0; i < 16; i++) begin
      if (ena && (in == 4'(i))) begin
        out[i] = 1'b1;
      end
    end
  end

endmodule

module rf_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [4*NUM_REQ-1:0]        req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        wr_ena,
  output logic [3:0]                  wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [15:0]                 wr_onehot
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]                 stat_grants,
  output logic [15:0]                 stat_stalls
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               wr_ena_q, wr_ena_d;
  logic [3:0]         wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W:0]     cand;
  logic [3:0]         sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Rotating priority search: first eligible requester starting at ptr.
  // Last cycle's grantee is masked so it never gets two cycles in a row.
  always_comb begin
    elig   = req & ~gnt_q;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && elig[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  // Pick the winner's address and data fields out of the packed request buses
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        sel_addr = req_addr[4*i +: 4];
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Next-state for grant, write port and pointer; address/data hold when idle
  always_comb begin
    gnt_d     = '0;
    wr_ena_d  = found;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    if (found) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_d[i] = (winner == PTR_W'(i));
      end
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      ptr_d     = (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end
  end

  // Arbitration state; an asynchronous reset drops any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  decoder_4_to_16 u_dec (
    .ena (wr_ena_q),
    .in  (wr_addr_q),
    .out (wr_onehot)
  );

`ifdef RF_ARB_STATS_EN
  logic [15:0] stat_grants_q, stat_grants_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;

  // Saturating counts of issued grants and of edges that left a requester waiting
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stalls_d = stat_stalls_q;
    if (found && (stat_grants_q != 16'hFFFF)) begin
      stat_grants_d = stat_grants_q + 16'd1;
    end
    if ((|(req & ~gnt_d)) && (stat_stalls_q != 16'hFFFF)) begin
      stat_stalls_d = stat_stalls_q + 16'd1;
    end
  end

  // Statistics registers, cleared together with the arbiter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter (NUM_REQ=4, DATA_W=32): a reference model
// pushes the expected registered outputs at every active edge and a checker
// pops and compares them half a cycle later, alongside directed scenarios.
module tb_rf_write_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [15:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         wr_ena;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [15:0]  wr_onehot;
`ifdef RF_ARB_STATS_EN
  logic [15:0]  stat_grants;
  logic [15:0]  stat_stalls;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  gnt;
    logic        ena;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [1:0]  ptr;
    logic [15:0] grants;
    logic [15:0] stalls;
  } exp_t;

  exp_t m_prev;
  exp_t step_e;
  exp_t sb_q[$];
  exp_t pop_e;

  rf_write_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_onehot (wr_onehot)
`ifdef RF_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and count it
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one requester's request bit, address and data
  task automatic applyStimulus(input int idx, input logic on, input logic [3:0] a, input logic [31:0] d);
    req[idx] = on;
    req_addr[idx*4 +: 4] = a;
    req_data[idx*32 +: 32] = d;
  endtask

  // Pulse reset away from clock edges so no edge sees a changing rst_n
  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Reference model step: what the registered outputs become at the next edge
  function automatic exp_t model_step(input logic [3:0] r, input logic [15:0] ra,
                                      input logic [127:0] rd, input exp_t prev);
    exp_t e;
    logic [3:0] el;
    logic       fnd;
    logic [1:0] w;
    logic [1:0] c;
    e   = prev;
    el  = r & ~prev.gnt;
    fnd = 1'b0;
    w   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      c = prev.ptr + 2'(k);
      if (!fnd && el[c]) begin
        fnd = 1'b1;
        w   = c;
      end
    end
    e.gnt = 4'b0000;
    e.ena = fnd;
    if (fnd) begin
      e.gnt  = 4'b0001 << w;
      e.addr = ra[{w, 2'b00} +: 4];
      e.data = rd[{w, 5'b00000} +: 32];
      e.ptr  = w + 2'd1;
      if (prev.grants != 16'hFFFF) e.grants = prev.grants + 16'd1;
    end
    if (((r & ~e.gnt) != 4'b0000) && (prev.stalls != 16'hFFFF)) e.stalls = prev.stalls + 16'd1;
    return e;
  endfunction

  always_comb step_e = model_step(req, req_addr, req_data, m_prev);

  // Model state advances on each edge; expected outputs go to the scoreboard
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= '{gnt: 4'd0, ena: 1'b0, addr: 4'd0, data: 32'd0, ptr: 2'd0, grants: 16'd0, stalls: 16'd0};
    end else begin
      m_prev <= step_e;
      sb_q.push_back(step_e);
    end
  end

  // Pop and compare half a cycle after each edge; reset discards pending entries
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      pop_e = sb_q.pop_front();
      checkOutput("sb_gnt", 64'(gnt), 64'(pop_e.gnt));
      checkOutput("sb_wr_ena", 64'(wr_ena), 64'(pop_e.ena));
      checkOutput("sb_wr_addr", 64'(wr_addr), 64'(pop_e.addr));
      checkOutput("sb_wr_data", 64'(wr_data), 64'(pop_e.data));
      checkOutput("sb_wr_onehot", 64'(wr_onehot), pop_e.ena ? (64'd1 << pop_e.addr) : 64'd0);
`ifdef RF_ARB_STATS_EN
      checkOutput("sb_stat_grants", 64'(stat_grants), 64'(pop_e.grants));
      checkOutput("sb_stat_stalls", 64'(stat_stalls), 64'(pop_e.stalls));
`endif
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int order[$];
  int gidx;
  logic hit;

  initial begin
    rst_n    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;

    // Reset with all requesters active: outputs zero, first grant goes to req0
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 4'(i + 4), 32'h1000_0000 + 32'(i));
    @(negedge clk);
    checkOutput("rst_gnt", 64'(gnt), 64'd0);
    checkOutput("rst_wr_ena", 64'(wr_ena), 64'd0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    checkOutput("rst_wr_onehot", 64'(wr_onehot), 64'd0);
`ifdef RF_ARB_STATS_EN
    checkOutput("rst_stat_grants", 64'(stat_grants), 64'd0);
    checkOutput("rst_stat_stalls", 64'(stat_stalls), 64'd0);
`endif
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_first_gnt", 64'(gnt), 64'h1);

    // Single request from requester 1
    doReset();
    applyStimulus(1, 1'b1, 4'hA, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("single_gnt", 64'(gnt), 64'h2);
    checkOutput("single_wr_ena", 64'(wr_ena), 64'h1);
    checkOutput("single_wr_addr", 64'(wr_addr), 64'hA);
    checkOutput("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    checkOutput("single_wr_onehot", 64'(wr_onehot), 64'h0400);
    applyStimulus(1, 1'b0, 4'hA, 32'hDEADBEEF);

    // Rotation: all four request, each drops on its grant; two batches
    doReset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 4'(i), 32'hA0 + 32'(i));
      order.delete();
      for (int cyc = 0; cyc < 12 && order.size() < 4; cyc++) begin
        @(negedge clk);
        hit = 1'b0;
        gidx = 0;
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) begin
            hit = 1'b1;
            gidx = i;
          end
        end
        if (hit) begin
          order.push_back(gidx);
          req = req & ~gnt;
        end
      end
      checkOutput("rot_count", 64'(order.size()), 64'd4);
      for (int i = 0; i < order.size(); i++) checkOutput("rot_order", 64'(order[i]), 64'(i));
      req = '0;
      @(negedge clk);
    end

    // Lone continuous requester gets every other cycle
    doReset();
    applyStimulus(0, 1'b1, 4'h3, 32'h0000_0033);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("lone_gnt", 64'(gnt), (i % 2 == 0) ? 64'h1 : 64'h0);
      checkOutput("lone_wr_ena", 64'(wr_ena), (i % 2 == 0) ? 64'h1 : 64'h0);
    end
    req = '0;

    // Two continuous requesters alternate with full throughput
    doReset();
    applyStimulus(0, 1'b1, 4'h0, 32'h0000_0000);
    applyStimulus(1, 1'b1, 4'h0, 32'h1111_1111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("pair_gnt", 64'(gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      checkOutput("pair_wr_ena", 64'(wr_ena), 64'h1);
    end
    req = '0;

    // Reset asserted while a write is in flight clears outputs immediately
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 4'(15 - i), 32'hC0DE_0000 + 32'(i));
    hit = 1'b0;
    for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
      @(posedge clk);
      #2;
      hit = wr_ena;
    end
    checkOutput("midrst_wait_wr_ena", 64'(hit), 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_ena", 64'(wr_ena), 64'd0);
    checkOutput("midrst_wr_onehot", 64'(wr_onehot), 64'd0);
    checkOutput("midrst_gnt", 64'(gnt), 64'd0);
`ifdef RF_ARB_STATS_EN
    checkOutput("midrst_stat_grants", 64'(stat_grants), 64'd0);
    checkOutput("midrst_stat_stalls", 64'(stat_stalls), 64'd0);
`endif
    @(negedge clk);
    #2;
    req = '0;
    rst_n = 1'b1;

    // Random traffic obeying the hold-until-granted handshake; small address
    // range so same-address writes from different requesters occur
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || gnt[i]) begin
          applyStimulus(i, ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 3)), $urandom);
        end
      end
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
